// File: rtl/data_cal_pkg.sv
// rtl/data_cal_pkg.sv - shared types, select codes and widths for the data_cal sequencer slice
package data_cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_C1    = 3'd1,
    S_C2    = 3'd2,
    S_C3    = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  localparam logic [1:0] SEL_LOAD = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_D    = 2'd3;

  localparam int SUM_W   = 5;
  localparam int TOTAL_W = 7;

  // nibble0 plus nibble k of a word; k=0 is never used by the datapath
  function automatic logic [SUM_W-1:0] nib_sum(input logic [15:0] w, input logic [1:0] k);
    logic [3:0] other;
    case (k)
      2'd1:    other = w[7:4];
      2'd2:    other = w[11:8];
      2'd3:    other = w[15:12];
      default: other = w[3:0];
    endcase
    return {1'b0, w[3:0]} + {1'b0, other};
  endfunction

endpackage

// File: rtl/data_cal_seq_if.sv
// rtl/data_cal_seq_if.sv - word-in / sums-out handshake bundle of the data_cal sequencer
interface data_cal_seq_if #(parameter int TAG_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [14:0]       out_sums;
  logic [6:0]        out_total;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_sums, out_total, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_sums, out_total, out_tag
  );
endinterface

// File: rtl/data_cal.sv
// rtl/data_cal.sv - nibble-sum datapath: sel=0 loads a word, sel=k registers nibble0+nibble k
module data_cal
  import data_cal_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      d,
  input  logic [1:0]       sel,
  output logic [SUM_W-1:0] out,
  output logic             validout
);

  logic [15:0] word_q;

  // load the word on sel=0, otherwise produce one registered nibble sum per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q   <= '0;
      out      <= '0;
      validout <= 1'b0;
    end else if (sel == SEL_LOAD) begin
      word_q   <= d;
      validout <= 1'b0;
    end else begin
      out      <= nib_sum(word_q, sel);
      validout <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cal_seq.sv
// rtl/data_cal_seq.sv - sequencer around data_cal; DATA_CAL_SEQ_CHK_EN enables the sticky err checker
module data_cal_seq
  import data_cal_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  data_cal_seq_if.slave bus,
  output logic          err
);

  seq_state_t        state_q, state_d;
  logic [1:0]        dp_sel;
  logic [15:0]       dp_d;
  logic [SUM_W-1:0]  dp_out;
  logic              dp_valid;
  logic [SUM_W-1:0]  s1_q, s2_q, s3_q;
  logic [TOTAL_W-1:0] total_q;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;

  assign accept = (state_q == S_IDLE) && bus.in_valid;

  data_cal u_dp (
    .clk      (clk),
    .rst      (rst),
    .d        (dp_d),
    .sel      (dp_sel),
    .out      (dp_out),
    .validout (dp_valid)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next state: fixed walk C1..DRAIN, only IDLE and DONE wait on handshakes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_C1;
      S_C1:    state_d = S_C2;
      S_C2:    state_d = S_C3;
      S_C3:    state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from the state register only
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    dp_d          = bus.in_data;
    dp_sel        = SEL_LOAD;
    case (state_q)
      S_C1:    dp_sel = SEL_B;
      S_C2:    dp_sel = SEL_C;
      S_C3:    dp_sel = SEL_D;
      S_DONE:  dp_d   = 16'h0000;
      default: dp_sel = SEL_LOAD;
    endcase
  end

  // capture the tag on acceptance and each sum one cycle after its datapath step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      total_q <= '0;
      tag_q   <= '0;
    end else begin
      if (accept) tag_q <= bus.in_tag;
      if (state_q == S_C2) s1_q <= dp_out;
      if (state_q == S_C3) s2_q <= dp_out;
      if (state_q == S_DRAIN) begin
        s3_q    <= dp_out;
        total_q <= {2'b00, s1_q} + {2'b00, s2_q} + {2'b00, dp_out};
      end
    end
  end

  assign bus.out_sums  = {s3_q, s2_q, s1_q};
  assign bus.out_total = total_q;
  assign bus.out_tag   = tag_q;

`ifdef DATA_CAL_SEQ_CHK_EN
  logic [15:0] word_q;
  logic        chk_en;
  logic [1:0]  chk_k;
  logic        err_q;

  // which nibble sum the datapath should be presenting at each capture edge
  always_comb begin
    chk_en = 1'b1;
    chk_k  = 2'd1;
    case (state_q)
      S_C2:    chk_k  = 2'd1;
      S_C3:    chk_k  = 2'd2;
      S_DRAIN: chk_k  = 2'd3;
      default: chk_en = 1'b0;
    endcase
  end

  // private word copy plus sticky error on missing validout or wrong sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) word_q <= bus.in_data;
      if (chk_en && (!dp_valid || (dp_out != nib_sum(word_q, chk_k)))) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_cal_seq.sv
// tb/tb_data_cal_seq.sv - directed vector bench for data_cal_seq
module tb_data_cal_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  data_cal_seq_if #(.TAG_W(4)) bus ();

  data_cal_seq #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int          s1;
    int          s2;
    int          s3;
    int          total;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] pack_sums(input vec_t v);
    logic [4:0] a, b, c;
    a = v.s1[4:0];
    b = v.s2[4:0];
    c = v.s3[4:0];
    return {c, b, a};
  endfunction

  // wait (at negedge) for out_valid, returning cycles elapsed; -1 on timeout
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  // accept one word from IDLE, check latency and all result fields, then consume it
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_tag   = v.tag;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hDEAD;
    wait_out(lat);
    chk({name, "_latency"}, lat, 32'd4);
    chk({name, "_sums"}, {17'd0, bus.out_sums}, {17'd0, pack_sums(v)});
    chk({name, "_total"}, {25'd0, bus.out_total}, v.total);
    chk({name, "_tag"}, {28'd0, bus.out_tag}, {28'd0, v.tag});
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int t[3];
    logic [14:0] hold_sums;

    vecs[0] = '{16'hF1A3, 4'h5, 13, 4, 18, 35};
    vecs[1] = '{16'hFFFF, 4'hA, 30, 30, 30, 90};
    vecs[2] = '{16'h0000, 4'h0, 0, 0, 0, 0};
    vecs[3] = '{16'h1234, 4'h3, 7, 6, 5, 18};
    vecs[4] = '{16'h8F07, 4'hC, 7, 22, 15, 44};

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_sums",  {17'd0, bus.out_sums}, 32'd0);
    chk("rst_out_total", {25'd0, bus.out_total}, 32'd0);
    chk("rst_out_tag",   {28'd0, bus.out_tag}, 32'd0);
    chk("rst_err",       {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // hold DONE with out_ready low while a competing word is offered
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[3].data;
    bus.in_tag   = vecs[3].tag;
    @(posedge clk);
    @(negedge clk);
    bus.in_data  = 16'hFFFF;
    bus.in_tag   = 4'hF;
    wait_out(lat);
    chk("hold_latency", lat, 32'd4);
    hold_sums = bus.out_sums;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      chk("hold_sums",      {17'd0, bus.out_sums}, {17'd0, pack_sums(vecs[3])});
      chk("hold_total",     {25'd0, bus.out_total}, 32'd18);
      chk("hold_tag",       {28'd0, bus.out_tag}, 32'd3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_vec(vecs[0], "after_hold");

    // back-to-back with in_valid held and out_ready tied high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = vecs[k + 2].data;
      bus.in_tag  = vecs[k + 2].tag;
      lat = 0;
      while (!bus.in_ready && lat < 20) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      chk("b2b_wait_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      wait_out(lat);
      chk("b2b_latency", lat, 32'd4);
      t[k] = cyc;
      chk("b2b_sums", {17'd0, bus.out_sums}, {17'd0, pack_sums(vecs[k + 2])});
      chk("b2b_tag",  {28'd0, bus.out_tag}, {28'd0, vecs[k + 2].tag});
      if (k == 2) bus.in_valid = 1'b0;
    end
    chk("b2b_period01", t[1] - t[0], 32'd6);
    chk("b2b_period12", t[2] - t[1], 32'd6);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // reset asserted during C3 after s1 has been captured
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[0].data;
    bus.in_tag   = vecs[0].tag;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_out_sums",  {17'd0, bus.out_sums}, 32'd0);
    chk("midrst_out_total", {25'd0, bus.out_total}, 32'd0);
    chk("midrst_out_tag",   {28'd0, bus.out_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_vec(vecs[4], "postrst");
    chk("err_clean", {31'd0, err}, 32'd0);

`ifdef DATA_CAL_SEQ_CHK_EN
    // suppress datapath validout during C3 to trip the sticky checker
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[3].data;
    bus.in_tag   = vecs[3].tag;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    force dut.u_dp.validout = 1'b0;
    @(posedge clk);
    @(negedge clk);
    release dut.u_dp.validout;
    wait_out(lat);
    chk("chk_err_set", {31'd0, err}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("chk_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b0;
    #1;
    chk("chk_err_cleared", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
